// File: rtl/fpx_mul.sv
// Three-stage pipelined floating-point multiplier for a parameterised {sign, exp, frac} format.
// Supports RNE/RTZ rounding, subnormals, IEEE special values and a sideband tag.
module fpx_mul #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned MANT_W = 10,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned W      = 1 + EXP_W + MANT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             rnd_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags
);

  localparam int XW    = EXP_W + 2;
  localparam int SW    = MANT_W + 1;
  localparam int PW    = 2 * SW;
  localparam int GW    = MANT_W + 4;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX  = (1 << EXP_W) - 1;
  localparam int SHMAX = MANT_W + 3;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  // Handshake and pipeline control
  logic init_q, stall, en, accept;
  logic s1_valid_q, s2_valid_q, out_valid_q;

  assign stall     = out_valid_q & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = init_q & ~stall;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (en) begin
        s1_valid_q <= accept;
        s2_valid_q <= s1_valid_q;
      end
    end
  end

  // S1: unpack, classify, exponent sum
  logic [EXP_W-1:0]    ea, eb, ea_eff, eb_eff;
  logic [MANT_W-1:0]   fa, fb;
  logic                a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic                s1_sign_d, s1_spec_d, s1_inv_d;
  logic [W-1:0]        s1_sres_d;
  logic signed [XW-1:0] s1_exp_d;

  always_comb begin
    ea     = a[MANT_W +: EXP_W];
    eb     = b[MANT_W +: EXP_W];
    fa     = a[MANT_W-1:0];
    fb     = b[MANT_W-1:0];
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_snan = a_nan & ~fa[MANT_W-1];
    b_snan = b_nan & ~fb[MANT_W-1];
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    a_zero = ~(|ea) & ~(|fa);
    b_zero = ~(|eb) & ~(|fb);
    ea_eff = (ea == '0) ? EXP_W'(1) : ea;
    eb_eff = (eb == '0) ? EXP_W'(1) : eb;
    s1_exp_d  = $signed({2'b00, ea_eff} + {2'b00, eb_eff} - XW'(BIAS));
    s1_sign_d = a[W-1] ^ b[W-1];

    s1_spec_d = 1'b1;
    s1_inv_d  = 1'b0;
    s1_sres_d = QNAN;
    if (a_nan || b_nan) begin
      s1_inv_d = a_snan | b_snan;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      s1_inv_d = 1'b1;
    end else if (a_inf || b_inf) begin
      s1_sres_d = {s1_sign_d, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      s1_sres_d = {s1_sign_d, {(W-1){1'b0}}};
    end else begin
      s1_spec_d = 1'b0;
    end
  end

  logic                 s1_sign_q, s1_spec_q, s1_inv_q, s1_rnd_q;
  logic [W-1:0]         s1_sres_q;
  logic [SW-1:0]        s1_ma_q, s1_mb_q;
  logic signed [XW-1:0] s1_exp_q;
  logic [TAG_W-1:0]     s1_tag_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_sign_q <= s1_sign_d;
      s1_spec_q <= s1_spec_d;
      s1_inv_q  <= s1_inv_d;
      s1_sres_q <= s1_sres_d;
      s1_ma_q   <= {|ea, fa};
      s1_mb_q   <= {|eb, fb};
      s1_exp_q  <= s1_exp_d;
      s1_rnd_q  <= rnd_mode;
      s1_tag_q  <= in_tag;
    end
  end

  // S2: significand multiply
  logic                 s2_sign_q, s2_spec_q, s2_inv_q, s2_rnd_q;
  logic [W-1:0]         s2_sres_q;
  logic [PW-1:0]        s2_prod_q;
  logic signed [XW-1:0] s2_exp_q;
  logic [TAG_W-1:0]     s2_tag_q;

  always_ff @(posedge clk) begin
    if (en && s1_valid_q) begin
      s2_sign_q <= s1_sign_q;
      s2_spec_q <= s1_spec_q;
      s2_inv_q  <= s1_inv_q;
      s2_sres_q <= s1_sres_q;
      s2_prod_q <= PW'(s1_ma_q) * PW'(s1_mb_q);
      s2_exp_q  <= s1_exp_q;
      s2_rnd_q  <= s1_rnd_q;
      s2_tag_q  <= s1_tag_q;
    end
  end

  // S3: normalise, round, pack
  function automatic int lzc(input logic [PW-1:0] v);
    int n = PW;
    for (int i = 0; i < PW; i++) begin
      if (v[i]) n = PW - 1 - i;
    end
    return n;
  endfunction

  logic [PW-1:0]     norm;
  logic [GW-1:0]     sig, sig_sh;
  logic [MANT_W+1:0] mant_r;
  logic [MANT_W-1:0] frac;
  logic              tiny, inexact, inc, ovf;
  int                lz, e_n, sh, exp_f;
  logic [W-1:0]      res_d;
  logic [3:0]        flg_d;

  always_comb begin
    lz   = lzc(s2_prod_q);
    norm = s2_prod_q << lz;
    // Leading one lands in the top bit, so the value is 1.x * 2^(e_n - bias)
    e_n  = int'(s2_exp_q) + 1 - lz;
    sig  = {norm[PW-1 -: MANT_W+3], |norm[MANT_W-2:0]};
    tiny = (e_n <= 0);
    sh   = 0;
    if (tiny) sh = ((1 - e_n) > SHMAX) ? SHMAX : (1 - e_n);
    sig_sh  = (sig >> sh) | GW'(|(sig & ~({GW{1'b1}} << sh)));
    inexact = |sig_sh[2:0];
    inc     = ~s2_rnd_q & sig_sh[2] & (sig_sh[1] | sig_sh[0] | sig_sh[3]);
    mant_r  = {1'b0, sig_sh[GW-1:3]} + {{(MANT_W+1){1'b0}}, inc};

    if (tiny) begin
      // A carry into the hidden bit promotes the subnormal to the smallest normal
      exp_f = int'(mant_r[MANT_W]);
      frac  = mant_r[MANT_W-1:0];
    end else if (mant_r[MANT_W+1]) begin
      exp_f = e_n + 1;
      frac  = mant_r[MANT_W:1];
    end else begin
      exp_f = e_n;
      frac  = mant_r[MANT_W-1:0];
    end
    ovf = (exp_f >= EMAX);

    flg_d = {1'b0, ovf, tiny & inexact, inexact | ovf};
    if (ovf) begin
      res_d = s2_rnd_q ? {s2_sign_q, EXP_W'(EMAX - 1), {MANT_W{1'b1}}}
                       : {s2_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else begin
      res_d = {s2_sign_q, EXP_W'(exp_f), frac};
    end
    if (s2_spec_q) begin
      res_d = s2_sres_q;
      flg_d = {s2_inv_q, 3'b000};
    end
  end

  logic [W-1:0]     result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [3:0]       flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_tag_q   <= '0;
      flags_q     <= '0;
    end else if (en) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        result_q  <= res_d;
        out_tag_q <= s2_tag_q;
        flags_q   <= flg_d;
      end
    end
  end

  assign result  = result_q;
  assign out_tag = out_tag_q;
  assign flags   = flags_q;

endmodule

// File: tb/tb_fpx_mul.sv
// Self-checking bench for fpx_mul (fp16): vector table streamed through a scoreboard,
// plus latency, back-pressure and mid-flight reset sequences.
module tb_fpx_mul;
  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int TAG_W  = 4;
  localparam int W      = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             rnd_mode = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       flags;

  fpx_mul #(.EXP_W(EXP_W), .MANT_W(MANT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .rnd_mode(rnd_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     res;
    logic [3:0]       flg;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rnd;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   n_out = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer, checks hold during stalls
  logic             prev_stall = 1'b0;
  logic [W-1:0]     prev_res = '0;
  logic [TAG_W-1:0] prev_tag = '0;
  logic [3:0]       prev_flg = '0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_result", result, prev_res);
        check("hold_tag", out_tag, prev_tag);
        check("hold_flags", flags, prev_flg);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_output got=%0h tag=%0h required=no_output", result, out_tag);
        end else begin
          mon_e = sbq.pop_front();
          check($sformatf("out_tag_exp%0h", mon_e.tag), out_tag, mon_e.tag);
          check($sformatf("result_tag%0h", mon_e.tag), result, mon_e.res);
          check($sformatf("flags_tag%0h", mon_e.tag), flags, mon_e.flg);
        end
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      prev_tag   = out_tag;
      prev_flg   = flags;
    end
  end

  // Call at a negedge; returns at a later negedge with in_valid low
  task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic rm,
                          input logic [TAG_W-1:0] tg, input logic [W-1:0] er,
                          input logic [3:0] ef);
    int tries = 0;
    a = ta; b = tb; rnd_mode = rm; in_tag = tg; in_valid = 1'b1;
    #1;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (in_ready) begin
      sbq.push_back('{tg, er, ef});
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=in_ready_low required=accept tag=%0h", tg);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      #3;
      n++;
    end
    check(nm, sbq.size(), 0);
  endtask

  vec_t vecs[20];
  int   out_before;
  int   k;

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vecs[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h3C00, 4'b0000};
    vecs[1]  = '{16'h7BFF, 16'h4000, 1'b0, 16'h7C00, 4'b0101};
    vecs[2]  = '{16'h7BFF, 16'h4000, 1'b1, 16'h7BFF, 4'b0101};
    vecs[3]  = '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'b1000};
    vecs[4]  = '{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'b0000};
    vecs[5]  = '{16'h0003, 16'h3800, 1'b0, 16'h0002, 4'b0011};
    vecs[6]  = '{16'h0003, 16'h3800, 1'b1, 16'h0001, 4'b0011};
    vecs[7]  = '{16'h0400, 16'h3800, 1'b0, 16'h0200, 4'b0000};
    vecs[8]  = '{16'h3C01, 16'h3E00, 1'b0, 16'h3E02, 4'b0001};
    vecs[9]  = '{16'h3C01, 16'h3E00, 1'b1, 16'h3E01, 4'b0001};
    vecs[10] = '{16'hFBFF, 16'h4000, 1'b1, 16'hFBFF, 4'b0101};
    vecs[11] = '{16'h7C00, 16'hC000, 1'b0, 16'hFC00, 4'b0000};
    vecs[12] = '{16'h8000, 16'h4500, 1'b0, 16'h8000, 4'b0000};
    vecs[13] = '{16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 4'b1000};
    vecs[14] = '{16'h0001, 16'h0001, 1'b0, 16'h0000, 4'b0011};
    vecs[15] = '{16'h03FF, 16'h3C01, 1'b0, 16'h0400, 4'b0011};
    vecs[16] = '{16'h03FF, 16'h3C01, 1'b1, 16'h03FF, 4'b0011};
    vecs[17] = '{16'h5640, 16'h5640, 1'b0, 16'h70E2, 4'b0000};
    vecs[18] = '{16'h0000, 16'hFC00, 1'b0, 16'h7E00, 4'b1000};
    vecs[19] = '{16'hC000, 16'hC200, 1'b0, 16'h4600, 4'b0000};

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_result", result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_flags", flags, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    #1 check("in_ready_after_edge", in_ready, 1);

    // Latency: accept in cycle 0, result visible in cycle 3
    @(negedge clk);
    a = 16'h3C00; b = 16'h3C00; rnd_mode = 1'b0; in_tag = 4'hA; in_valid = 1'b1;
    #1 check("lat_accept", in_ready, 1);
    sbq.push_back('{4'hA, 16'h3C00, 4'b0000});
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("lat_cycle1", out_valid, 0);
    @(negedge clk);
    #1 check("lat_cycle2", out_valid, 0);
    @(negedge clk);
    #1 check("lat_cycle3", out_valid, 1);
    @(negedge clk);
    #1 check("lat_single_pulse", out_valid, 0);

    // Vector table, streamed back-to-back
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      drive_op(vecs[i].a, vecs[i].b, vecs[i].rnd, TAG_W'(i), vecs[i].res, vecs[i].flg);
    end
    drain("table_drain");

    // Back-pressure: out_ready low for cycles 4..7 of a 5-op stream
    @(negedge clk);
    out_before = n_out;
    k = 0;
    for (int c = 0; c < 24; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (k < 5) begin
        a = 16'h4000 + 16'(k * 16'h0100); b = 16'h3C00; rnd_mode = 1'b0;
        in_tag = TAG_W'(k + 5); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 4 && c <= 7) check($sformatf("stall_in_ready_c%0d", c), in_ready, 0);
      if (in_valid && in_ready) begin
        sbq.push_back('{TAG_W'(k + 5), 16'h4000 + 16'(k * 16'h0100), 4'b0000});
        k++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("stream_drain");
    check("stream_count", n_out - out_before, 5);

    // Reset with three operations in flight
    @(negedge clk);
    drive_op(16'h4000, 16'h4000, 1'b0, 4'h1, 16'h4400, 4'b0000);
    drive_op(16'h4200, 16'h4000, 1'b0, 4'h2, 16'h4600, 4'b0000);
    drive_op(16'h4400, 16'h4000, 1'b0, 4'h3, 16'h4800, 4'b0000);
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_result", result, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1 check($sformatf("post_rst_idle_c%0d", c), out_valid, 0);
    end

    // Function resumes after reset
    @(negedge clk);
    drive_op(16'h3C00, 16'h4000, 1'b1, 4'h7, 16'h4000, 4'b0000);
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpx_mul.md
FPX_MUL -- requirements
Module: fpx_mul

Interface
REQ-001 SHALL have parameter EXP_W, default 5: exponent field width, legal range 3..11.
REQ-002 SHALL have parameter MANT_W, default 10: fraction field width, legal range 2..52.
REQ-003 SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-004 SHALL have parameter W, derived, equal to 1+EXP_W+MANT_W: operand width. Defaults give IEEE binary16.
REQ-005 SHALL have port clk, input, width 1: single clock; all state is updated on the rising edge.
REQ-006 SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, width 1: operands present.
REQ-008 SHALL have port in_ready, output, width 1: block accepts an operation this cycle.
REQ-009 SHALL have ports a and b, input, width W each: operands as {sign, exp, frac}, exponent bias 2^(EXP_W-1)-1.
REQ-010 SHALL have port rnd_mode, input, width 1: 0 = round-to-nearest-even (RNE), 1 = round-toward-zero (RTZ); sampled with the operands.
REQ-011 SHALL have port in_tag, input, width TAG_W: opaque sideband data.
REQ-012 SHALL have port out_valid, output, width 1: result present.
REQ-013 SHALL have port out_ready, input, width 1: downstream accepts the result.
REQ-014 SHALL have port result, output, width W: product.
REQ-015 SHALL have port out_tag, output, width TAG_W: in_tag of the same operation.
REQ-016 SHALL have port flags, output, width 4: {invalid, overflow, underflow, inexact}.

Function
REQ-017 SHALL be a 3-stage pipeline: S1 unpack/classify/exponent sum; S2 significand multiply, width 2*(MANT_W+1); S3 normalise, round, pack.
REQ-018 SHALL carry a valid bit per stage; an operation transfers in when in_valid and in_ready are both high, and transfers out when out_valid and out_ready are both high.
REQ-019 SHALL define stall = out_valid and not out_ready; while stall is high all stages hold and in_ready = 0, otherwise in_ready = 1.
REQ-020 SHALL give a latency of exactly 3 cycles from accept to out_valid when not stalled, with throughput of 1 operation per cycle.
REQ-021 SHALL keep result, out_tag and flags stable while out_valid is high and out_ready is low.
REQ-022 SHALL treat subnormal inputs with an effective exponent of 1 and a hidden bit of 0; the exponent sum uses signed width EXP_W+2.
REQ-023 SHALL set the sign to sign_a XOR sign_b for all results, including zero and infinity, but not NaN.
REQ-024 SHALL handle specials with this priority: any NaN operand -> canonical qNaN; Inf*0 -> qNaN with invalid=1; Inf*x -> Inf; 0*x -> signed zero.
REQ-025 SHALL encode the canonical qNaN as sign 0, exponent all ones, frac MSB 1, other frac bits 0 (0x7E00 for fp16).
REQ-026 SHALL set invalid only for Inf*0 or when an operand is an sNaN (frac MSB 0).
REQ-027 SHALL normalise the product by a right shift of 1 and exponent+1 when the product MSB is set; a product with a subnormal operand SHALL be left-normalised by leading-zero count.
REQ-028 SHALL retain guard, round and sticky bits through all normalisation and denormalisation shifts.
REQ-029 SHALL round as follows: RNE increments on guard and (round or sticky or lsb); RTZ truncates.
REQ-030 SHALL, on a rounding carry-out, renormalise and increment the exponent.
REQ-031 SHALL detect overflow when the biased exponent is >= all-ones after rounding; the result is Inf under RNE or max finite under RTZ, and flags overflow=1 and inexact=1.
REQ-032 SHALL produce a subnormal when the biased exponent is <= 0: shift right by 1-exp, capped at MANT_W+3 with sticky collected, then round.
REQ-033 SHALL produce a normal result when subnormal rounding carries into the hidden bit.
REQ-034 SHALL set underflow when the result is tiny before rounding and inexact.
REQ-035 SHALL set inexact whenever any discarded bit is nonzero.
REQ-036 SHALL set all flags to 0 for special-case results other than invalid.

Reset
REQ-037 SHALL, while rst_n is low, immediately clear all stage valid bits and drive out_valid=0, result=0, out_tag=0, flags=0, in_ready=0.
REQ-038 SHALL drive in_ready=1 on the first clock edge after rst_n deasserts.
REQ-039 SHALL discard in-flight operations on reset mid-operation and produce no spurious out_valid afterwards.

Verification (fp16 defaults)
REQ-040 SHALL cover: a=0x3C00, b=0x3C00, RNE, out_ready=1 -> out_valid exactly 3 cycles later with result 0x3C00, flags 0000, tag echoed.
REQ-041 SHALL cover: a=0x7BFF, b=0x4000 -> RNE result 0x7C00 with flags 0101; RTZ result 0x7BFF with flags 0101.
REQ-042 SHALL cover: a=0x7C00, b=0x0000 -> result 0x7E00 with flags 1000; a=0x7E01, b=0x3C00 -> result 0x7E00 with flags 0000.
REQ-043 SHALL cover: a=0x0003, b=0x3800 -> RNE result 0x0002, RTZ result 0x0001, flags 0011 in both modes; a=0x0400, b=0x3800 -> result 0x0200 with flags 0000.
REQ-044 SHALL cover: stream 5 operations back-to-back, out_ready=0 for cycles 4-7 -> in_ready=0 during the stall, no result lost or duplicated, order and tags preserved.
REQ-045 SHALL cover: assert rst_n=0 with 3 operations in flight -> out_valid=0 immediately, and no output follows until new input.
